// File: rtl/lb_cycle_initiator.sv
// Local-bus cycle initiator: turns a request/done handshake into one TSn/TACKn transfer.
// Optional WAIT-state timeout abort is enabled by defining LB_TIMEOUT_EN.
module lb_cycle_initiator #(
   parameter int RECOVER_CYCLES = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK80,
   input  logic        RESET,
   input  logic        REQ,
   input  logic        REQ_RnW,
   input  logic [1:0]  REQ_SIZ,
   input  logic [23:0] REQ_A,
   input  logic [31:0] REQ_D,
   output logic        READY,
   output logic        DONE,
   output logic        ERR,
   output logic [31:0] RDATA,
   output logic        TSn,
   input  logic        TACKn,
   output logic        RnW,
   output logic [1:0]  SIZ,
   output logic [23:0] A,
   output logic [31:0] D_OUT,
   output logic        D_OE,
   input  logic [31:0] D_IN,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RECOVER} state_t;

   localparam logic [3:0] L_REC_LAST = 4'(RECOVER_CYCLES - 1);

   if (RECOVER_CYCLES < 1 || RECOVER_CYCLES > 15 ||
       TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_param_check
      $error("lb_cycle_initiator: RECOVER_CYCLES or TIMEOUT_CYCLES out of range");
   end

   state_t      r_state;
   logic        r_ready;
   logic        r_done;
   logic        r_err;
   logic [31:0] r_rdata;
   logic        r_tsn;
   logic        r_rnw;
   logic [1:0]  r_siz;
   logic [23:0] r_a;
   logic [31:0] r_dout;
   logic        r_doe;
   logic [3:0]  r_rcnt;
`ifdef LB_TIMEOUT_EN
   localparam logic [9:0] L_TO_LAST = 10'(TIMEOUT_CYCLES - 1);
   logic [9:0]  r_wcnt;
`endif

   // Alignment rules: line size never legal, word needs even address, long needs A[1:0]=00.
   logic w_illegal;
   assign w_illegal = (REQ_SIZ == 2'b11) ||
                      (REQ_SIZ == 2'b10 && REQ_A[0]) ||
                      (REQ_SIZ == 2'b00 && REQ_A[1:0] != 2'b00);

   always_ff @(posedge CLK80) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0;
         r_tsn   <= 1'b1;
         r_rnw   <= 1'b1;
         r_siz   <= 2'b00;
         r_a     <= 24'h0;
         r_dout  <= 32'h0;
         r_doe   <= 1'b0;
         r_rcnt  <= 4'h0;
`ifdef LB_TIMEOUT_EN
         r_wcnt  <= 10'h0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               // READY low in IDLE marks the single error-completion cycle.
               if (!r_ready) begin
                  r_ready <= 1'b1;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
               end else if (REQ) begin
                  r_a     <= REQ_A;
                  r_siz   <= REQ_SIZ;
                  r_dout  <= REQ_D;
                  r_ready <= 1'b0;
                  if (w_illegal) begin
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end else begin
                     r_state <= S_START;
                     r_tsn   <= 1'b0;
                     r_rnw   <= REQ_RnW;
                     r_doe   <= ~REQ_RnW;
                  end
               end
            end
            S_START: begin
               r_tsn   <= 1'b1;
               r_state <= S_WAIT;
`ifdef LB_TIMEOUT_EN
               r_wcnt  <= 10'h0;
`endif
            end
            S_WAIT: begin
               if (!TACKn) begin
                  if (r_rnw) r_rdata <= D_IN;
                  r_done  <= 1'b1;
                  r_err   <= 1'b0;
                  r_doe   <= 1'b0;
                  r_rnw   <= 1'b1;
                  r_rcnt  <= L_REC_LAST;
                  r_state <= S_RECOVER;
`ifdef LB_TIMEOUT_EN
               end else if (r_wcnt == L_TO_LAST) begin
                  r_rdata <= 32'hFFFF_FFFF;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_doe   <= 1'b0;
                  r_rnw   <= 1'b1;
                  r_rcnt  <= L_REC_LAST;
                  r_state <= S_RECOVER;
               end else begin
                  r_wcnt  <= r_wcnt + 10'd1;
`endif
               end
            end
            S_RECOVER: begin
               r_done <= 1'b0;
               r_err  <= 1'b0;
               if (r_rcnt == 4'h0) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_rcnt <= r_rcnt - 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign READY       = r_ready;
   assign DONE        = r_done;
   assign ERR         = r_err;
   assign RDATA       = r_rdata;
   assign TSn         = r_tsn;
   assign RnW         = r_rnw;
   assign SIZ         = r_siz;
   assign A           = r_a;
   assign D_OUT       = r_dout;
   assign D_OE        = r_doe;
   assign o_dbg_state = r_state;

endmodule
